// File: rtl/sort4_gather_pkg.sv
// Shared constants for the sort4 feeder: widths, group size, pad word and FSM encodings.
package sort4_gather_pkg;
  localparam int W_DEF = 4;
  localparam int GRP   = 4;
  localparam int SEQ_W = 8;
  localparam int LEN_W = 3;

  // Padding is all-ones so padded slots sort after every real value.
  localparam logic [31:0] PAD_ALL = '1;

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [LEN_W-1:0] len;
  } grp_meta_t;
endpackage

// File: rtl/sort4_gather_outreg.sv
// Output register for one 4-word group with valid/ready and a per-load sequence number.
// Latency: load strobe visible on outputs after 1 edge.
// Backpressure: words held while out_valid && !out_ready; load may coincide with a take.
module sort4_gather_outreg
  import sort4_gather_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [GRP*W-1:0]   ld_data,
`ifdef SORT4_GATHER_FLUSH_EN
  input  logic [LEN_W-1:0]   ld_len,
  output logic [LEN_W-1:0]   out_len,
`endif
  input  logic               out_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_a,
  output logic [W-1:0]       out_b,
  output logic [W-1:0]       out_c,
  output logic [W-1:0]       out_d,
  output logic [SEQ_W-1:0]   out_seq
);
  // Number handed to the next loaded group; out_seq shows the current one.
  logic [SEQ_W-1:0] nxt_seq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      out_d     <= '0;
      out_seq   <= '0;
      nxt_seq   <= '0;
    end else if (load) begin
      {out_a, out_b, out_c, out_d} <= ld_data;
      out_valid <= 1'b1;
      out_seq   <= nxt_seq;
      nxt_seq   <= nxt_seq + SEQ_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SORT4_GATHER_FLUSH_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      out_len <= '0;
    else if (load)
      out_len <= ld_len;
  end
`endif
endmodule

// File: rtl/sort4_gather.sv
// Serial-to-parallel feeder for sort4: packs four beats into one registered group (SORT4_GATHER_FLUSH_EN adds flush/out_len).
// Latency: 1 cycle from 4th accepted beat to out_valid.
// Backpressure: one spare group held in the assembly buffer; in_ready drops only while it is occupied.
module sort4_gather
  import sort4_gather_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       in_data,
  input  logic               in_valid,
  output logic               in_ready,
`ifdef SORT4_GATHER_FLUSH_EN
  input  logic               flush,
  output logic [LEN_W-1:0]   out_len,
`endif
  output logic [W-1:0]       out_a,
  output logic [W-1:0]       out_b,
  output logic [W-1:0]       out_c,
  output logic [W-1:0]       out_d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEQ_W-1:0]   out_seq
);
  logic [0:0]       state;
  logic [1:0]       cnt;
  logic [W-1:0]     slot [GRP];
  logic [W-1:0]     grp  [GRP];
  logic             acc;
  logic             take;
  logic             room;
  logic             close;
  logic             load;
  logic [GRP*W-1:0] ld_data;

  assign in_ready = rst_n && (state == FILL);
  assign acc      = in_valid && in_ready;
  assign take     = out_valid && out_ready;
  assign room     = !out_valid || out_ready;

  // Group as it would look if closed this cycle: stored slots, the incoming beat, then padding.
  always_comb begin
    for (int i = 0; i < GRP; i++) begin
      if (i < int'(cnt))
        grp[i] = slot[i];
      else if (acc && (i == int'(cnt)))
        grp[i] = in_data;
      else
        grp[i] = PAD_ALL[W-1:0];
    end
  end

`ifdef SORT4_GATHER_FLUSH_EN
  logic [LEN_W-1:0] grp_len;
  logic [LEN_W-1:0] hold_len;
  logic [LEN_W-1:0] ld_len;

  assign grp_len = {1'b0, cnt} + {{(LEN_W-1){1'b0}}, acc};
  assign close   = (state == FILL) &&
                   ((acc && (cnt == 2'd3)) || (flush && (grp_len != '0)));
  assign ld_len  = (state == HOLD) ? hold_len : grp_len;

  always_ff @(posedge clk) begin
    if (!rst_n)
      hold_len <= '0;
    else if ((state == FILL) && close && !room)
      hold_len <= grp_len;
  end
`else
  assign close = acc && (cnt == 2'd3);
`endif

  assign load    = ((state == FILL) && close && room) || ((state == HOLD) && take);
  assign ld_data = (state == HOLD) ? {slot[0], slot[1], slot[2], slot[3]}
                                   : {grp[0], grp[1], grp[2], grp[3]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      cnt   <= '0;
      for (int i = 0; i < GRP; i++)
        slot[i] <= '0;
    end else if (state == FILL) begin
      if (close) begin
        cnt <= '0;
        // Output still busy: park the whole group and stop accepting.
        if (!room) begin
          state <= HOLD;
          for (int i = 0; i < GRP; i++)
            slot[i] <= grp[i];
        end
      end else if (acc) begin
        slot[cnt] <= in_data;
        cnt       <= cnt + 2'd1;
      end
    end else if (take) begin
      state <= FILL;
      cnt   <= '0;
    end
  end

  sort4_gather_outreg #(.W(W)) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .ld_data   (ld_data),
`ifdef SORT4_GATHER_FLUSH_EN
    .ld_len    (ld_len),
    .out_len   (out_len),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_seq   (out_seq)
  );
endmodule

// File: tb/tb_sort4_gather.sv
// Directed self-checking bench for sort4_gather; flush cases run when SORT4_GATHER_FLUSH_EN is defined.
module tb_sort4_gather;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_a, out_b, out_c, out_d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_seq;
`ifdef SORT4_GATHER_FLUSH_EN
  logic       flush;
  logic [2:0] out_len;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sort4_gather #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef SORT4_GATHER_FLUSH_EN
    .flush     (flush),
    .out_len   (out_len),
`endif
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_seq   (out_seq)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic beat(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_grp;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
`ifdef SORT4_GATHER_FLUSH_EN
    flush     = 1'b0;
`endif
    cyc();
    cyc();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_words", 32'({out_a, out_b, out_c, out_d}), 0);
    chk("rst_seq", 32'(out_seq), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    cyc();
    chk("in_ready_after_rst", 32'(in_ready), 1);

    // First group 3,1,4,2
    beat(4'd3);
    beat(4'd1);
    beat(4'd4);
    chk("g0_not_yet", 32'(out_valid), 0);
    beat(4'd2);
    chk("g0_valid", 32'(out_valid), 1);
    chk("g0_words", 32'({out_a, out_b, out_c, out_d}), 32'h3142);
    chk("g0_seq", 32'(out_seq), 0);
    in_valid = 1'b0;
    cyc();
    chk("g0_taken", 32'(out_valid), 0);
    chk("g0_words_kept", 32'({out_a, out_b, out_c, out_d}), 32'h3142);

    // Streaming 0..7 with consumer always ready
    for (int k = 0; k < 8; k++) begin
      chk("stream_in_ready", 32'(in_ready), 1);
      beat(4'(k));
      if (k == 3) begin
        chk("s1_words", 32'({out_a, out_b, out_c, out_d}), 32'h0123);
        chk("s1_seq", 32'(out_seq), 1);
      end
      if (k == 4) chk("s1_drained", 32'(out_valid), 0);
      if (k == 7) begin
        chk("s2_words", 32'({out_a, out_b, out_c, out_d}), 32'h4567);
        chk("s2_seq", 32'(out_seq), 2);
        chk("s2_valid", 32'(out_valid), 1);
      end
    end
    in_valid = 1'b0;
    cyc();

    // Backpressure: consumer stalls across two groups
    out_ready = 1'b0;
    beat(4'h8);
    beat(4'h9);
    beat(4'hA);
    beat(4'hB);
    chk("bp_a_words", 32'({out_a, out_b, out_c, out_d}), 32'h89AB);
    chk("bp_a_seq", 32'(out_seq), 3);
    beat(4'hC);
    beat(4'hD);
    beat(4'hE);
    chk("bp_a_stable", 32'({out_a, out_b, out_c, out_d}), 32'h89AB);
    chk("bp_in_ready_pre", 32'(in_ready), 1);
    beat(4'hF);
    chk("bp_hold_in_ready", 32'(in_ready), 0);
    chk("bp_hold_valid", 32'(out_valid), 1);
    beat(4'h0);
    chk("bp_ignored_in_ready", 32'(in_ready), 0);
    chk("bp_a_still", 32'({out_a, out_b, out_c, out_d}), 32'h89AB);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc();
    chk("bp_b_words", 32'({out_a, out_b, out_c, out_d}), 32'hCDEF);
    chk("bp_b_seq", 32'(out_seq), 4);
    chk("bp_b_valid", 32'(out_valid), 1);
    chk("bp_in_ready_back", 32'(in_ready), 1);

    // 4th beat lands on the same edge the held group is taken
    out_ready = 1'b0;
    beat(4'h1);
    beat(4'h2);
    beat(4'h3);
    chk("nb_b_stable", 32'({out_a, out_b, out_c, out_d}), 32'hCDEF);
    out_ready = 1'b1;
    beat(4'h5);
    chk("nb_valid", 32'(out_valid), 1);
    chk("nb_words", 32'({out_a, out_b, out_c, out_d}), 32'h1235);
    chk("nb_seq", 32'(out_seq), 5);
    in_valid = 1'b0;
    cyc();
    chk("nb_drained", 32'(out_valid), 0);

    // Reset mid-group discards the partial group
    beat(4'h7);
    beat(4'h7);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    cyc();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_words", 32'({out_a, out_b, out_c, out_d}), 0);
    chk("mid_rst_seq", 32'(out_seq), 0);
    rst_n = 1'b1;
    cyc();
    beat(4'h9);
    beat(4'h8);
    beat(4'h7);
    beat(4'h6);
    chk("post_rst_words", 32'({out_a, out_b, out_c, out_d}), 32'h9876);
    chk("post_rst_seq", 32'(out_seq), 0);
`ifdef SORT4_GATHER_FLUSH_EN
    chk("full_len", 32'(out_len), 4);
`endif
    in_valid = 1'b0;
    cyc();

`ifdef SORT4_GATHER_FLUSH_EN
    beat(4'h5);
    beat(4'h6);
    in_valid = 1'b0;
    flush    = 1'b1;
    cyc();
    chk("fl_words", 32'({out_a, out_b, out_c, out_d}), 32'h56FF);
    chk("fl_len", 32'(out_len), 2);
    chk("fl_valid", 32'(out_valid), 1);
    chk("fl_seq", 32'(out_seq), 1);
    cyc();
    chk("fl_empty_ignored", 32'(out_valid), 0);
    beat(4'h3);
    chk("fl_same_cycle_words", 32'({out_a, out_b, out_c, out_d}), 32'h3FFF);
    chk("fl_same_cycle_len", 32'(out_len), 1);
    chk("fl_same_cycle_seq", 32'(out_seq), 2);
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc();
`endif

    // Sequence wrap across 258 back-to-back groups
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    for (int g = 0; g < 258; g++) begin
      for (int k = 0; k < 4; k++)
        beat(4'(g + k));
      if (g >= 255) begin
        exp_grp = {4'(g), 4'(g + 1), 4'(g + 2), 4'(g + 3)};
        chk("wrap_seq", 32'(out_seq), 32'(g % 256));
        chk("wrap_words", 32'({out_a, out_b, out_c, out_d}), 32'(exp_grp));
      end
    end
    in_valid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
